// File: rtl/vscale_fetch_buffer.sv
// Decoupled instruction fetch unit: sequential PC generation, one outstanding imem
// request, and a DEPTH-entry prefetch FIFO feeding decode with valid/ready.
module vscale_fetch_buffer #(
  parameter int                 XPR_LEN    = 32,
  parameter int                 INST_WIDTH = 32,
  parameter int                 DEPTH      = 4,
  parameter logic [XPR_LEN-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [XPR_LEN-1:0]           redirect_pc,
  output logic                         imem_req,
  output logic [XPR_LEN-1:0]           imem_addr,
  input  logic                         imem_wait,
  input  logic [INST_WIDTH-1:0]        imem_rdata,
  input  logic                         imem_badmem_e,
  output logic                         inst_valid,
  output logic [INST_WIDTH-1:0]        inst,
  output logic [XPR_LEN-1:0]           inst_pc,
  output logic                         inst_fault,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [INST_WIDTH-1:0] instMem_q [DEPTH];
  logic [XPR_LEN-1:0]    pcMem_q   [DEPTH];
  logic [DEPTH-1:0]      faultMem_q;
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [XPR_LEN-1:0]    fetchPc_q, fetchPc_d;
  logic [XPR_LEN-1:0]    reqPc_q;
  logic                  inflight_q;
  logic                  halted_q, halted_d;
  logic                  push, pop, accept;
  logic [CW:0]           slotsAfter;
  logic                  redirectPcUnused;

  assign redirectPcUnused = ^redirect_pc[1:0];

  assign inst_valid = !reset && (count_q != '0);
  assign inst       = instMem_q[rdPtr_q];
  assign inst_pc    = pcMem_q[rdPtr_q];
  assign inst_fault = inst_valid && faultMem_q[rdPtr_q];
  assign occupancy  = reset ? '0 : count_q;
  assign imem_addr  = fetchPc_q;

  // Memory latency is one cycle, so the only response that can be in flight during a
  // redirect is the one landing right now; blocking its push is the whole squash.
  always_comb begin
    push       = inflight_q && !redirect && !reset;
    pop        = inst_valid && inst_ready && !redirect;
    slotsAfter = (CW+1)'(count_q) + (CW+1)'(push) - (CW+1)'(pop);
    imem_req   = !reset && !halted_q && !redirect && (slotsAfter < (CW+1)'(DEPTH));
    accept     = imem_req && !imem_wait;
  end

  always_comb begin
    fetchPc_d = fetchPc_q;
    halted_d  = halted_q;
    count_d   = count_q;
    if (redirect) begin
      fetchPc_d = {redirect_pc[XPR_LEN-1:2], 2'b00};
      halted_d  = 1'b0;
      count_d   = '0;
    end else begin
      if (accept) fetchPc_d = fetchPc_q + XPR_LEN'(4);
      if (push && imem_badmem_e) halted_d = 1'b1;
      count_d = CW'(slotsAfter);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      reqPc_q    <= RESET_PC;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      inflight_q <= accept;
      if (accept) reqPc_q <= fetchPc_q;
      if (redirect) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + 1'b1;
        if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr_q]  <= imem_rdata;
      pcMem_q[wrPtr_q]    <= reqPc_q;
      faultMem_q[wrPtr_q] <= imem_badmem_e;
    end
  end

endmodule

// File: tb/tb_vscale_fetch_buffer.sv
// Bench for vscale_fetch_buffer: directed scenarios plus random traffic, checked
// against a queue-based reference model; a second instance exercises PC wrap.
module tb_vscale_fetch_buffer;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, redirect = 1'b0, imemWait = 1'b0, instReady = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReq, instValid, instFault, imemBadmem;
  logic [31:0] imemAddr, imemRdata, inst, instPc;
  logic [2:0]  occupancy;
  logic [31:0] respAddr = '0;

  logic        wReset = 1'b1, wReq, wValid, wFault;
  logic [31:0] wAddr, wRdata, wInst, wPc;
  logic [2:0]  wOcc;
  logic [31:0] wRespAddr = '0;

  logic        faultOn = 1'b0, randFaults = 1'b0;
  logic [31:0] faultAddr = '0;

  int checks = 0;
  int errors = 0;

  entry_t      mQ[$];
  logic [31:0] mPc = '0, mPendPc = '0;
  logic        mPendValid = 1'b0, mHalted = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic faultRule(input logic [31:0] a);
    return faultOn && ((a == faultAddr) || (randFaults && a[7:2] == 6'h2A));
  endfunction

  // Instruction memory: answers one cycle after each accepted request.
  always @(posedge clk) begin
    if (imemReq && !imemWait) respAddr <= imemAddr;
    if (wReq) wRespAddr <= wAddr;
  end
  assign imemRdata  = memWord(respAddr);
  assign imemBadmem = faultRule(respAddr);
  assign wRdata     = memWord(wRespAddr);

  vscale_fetch_buffer #(.XPR_LEN(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirectPc),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_wait(imemWait),
    .imem_rdata(imemRdata), .imem_badmem_e(imemBadmem),
    .inst_valid(instValid), .inst(inst), .inst_pc(instPc), .inst_fault(instFault),
    .inst_ready(instReady), .occupancy(occupancy)
  );

  vscale_fetch_buffer #(.XPR_LEN(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dutWrap (
    .clk(clk), .reset(wReset), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(wReq), .imem_addr(wAddr), .imem_wait(1'b0),
    .imem_rdata(wRdata), .imem_badmem_e(1'b0),
    .inst_valid(wValid), .inst(wInst), .inst_pc(wPc), .inst_fault(wFault),
    .inst_ready(1'b1), .occupancy(wOcc)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic driveOnly(input logic rst, input logic rd, input logic [31:0] rpc,
                           input logic wt, input logic rdy);
    reset      = rst;
    redirect   = rd;
    redirectPc = rpc;
    imemWait   = wt;
    instReady  = rdy;
  endtask

  // One clock cycle: drive inputs, compare DUT to the model, then advance the model.
  task automatic applyStimulus(input logic rst, input logic rd, input logic [31:0] rpc,
                               input logic wt, input logic rdy);
    int     sz;
    logic   landing, popNow, expReq;
    entry_t e;
    driveOnly(rst, rd, rpc, wt, rdy);
    #1;
    sz      = mQ.size();
    landing = mPendValid && !rd;
    popNow  = (sz > 0) && rdy && !rd;
    expReq  = !rst && !mHalted && !rd && ((sz + int'(landing) - int'(popNow)) < DEPTH);
    if (rst) begin
      checkOutput("rst_req", 64'(imemReq), 64'(0));
      checkOutput("rst_valid", 64'(instValid), 64'(0));
      checkOutput("rst_occ", 64'(occupancy), 64'(0));
      checkOutput("rst_fault", 64'(instFault), 64'(0));
    end else begin
      checkOutput("valid", 64'(instValid), 64'(sz > 0));
      checkOutput("occupancy", 64'(occupancy), 64'(sz));
      if (sz > 0) begin
        checkOutput("inst", 64'(inst), 64'(mQ[0].inst));
        checkOutput("inst_pc", 64'(instPc), 64'(mQ[0].pc));
        checkOutput("inst_fault", 64'(instFault), 64'(mQ[0].fault));
      end
      checkOutput("imem_req", 64'(imemReq), 64'(expReq));
      if (expReq) checkOutput("imem_addr", 64'(imemAddr), 64'(mPc));
    end
    @(posedge clk);
    if (rst) begin
      mQ.delete();
      mPc        = 32'h0;
      mPendValid = 1'b0;
      mHalted    = 1'b0;
    end else if (rd) begin
      mQ.delete();
      mPc        = rpc & ~32'h3;
      mPendValid = 1'b0;
      mHalted    = 1'b0;
    end else begin
      if (popNow) void'(mQ.pop_front());
      if (mPendValid) begin
        e = '{memWord(mPendPc), mPendPc, faultRule(mPendPc)};
        mQ.push_back(e);
        if (e.fault) mHalted = 1'b1;
      end
      if (expReq && !wt) begin
        mPendValid = 1'b1;
        mPendPc    = mPc;
        mPc        = mPc + 32'd4;
      end else begin
        mPendValid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          got;
    logic [31:0] gotPc [4];
    logic [31:0] gotInst [4];
    logic [31:0] ePc;

    // Reset held, then plain sequential fetch with decode always ready.
    repeat (2) applyStimulus(1, 0, 0, 0, 1);
    repeat (12) applyStimulus(0, 0, 0, 0, 1);

    // Backpressure fills exactly DEPTH entries, then drains in order.
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("bp_occ_full", 64'(occupancy), 64'(DEPTH));
    checkOutput("bp_req_off", 64'(imemReq), 64'(0));
    repeat (8) applyStimulus(0, 0, 0, 0, 1);

    // Memory wait on address 0x8 holds the request stable.
    applyStimulus(0, 1, 32'h8, 0, 1);
    for (int i = 0; i < 3; i++) begin
      driveOnly(0, 0, 0, 1, 1);
      #1;
      checkOutput("wait_addr", 64'(imemAddr), 64'h8);
      checkOutput("wait_req", 64'(imemReq), 64'(1));
      applyStimulus(0, 0, 0, 1, 1);
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 1);

    // Redirect while the 0x10 response is landing: it must be dropped.
    applyStimulus(0, 1, 32'h10, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h203, 0, 1);
    driveOnly(0, 0, 0, 0, 1);
    #1;
    checkOutput("redir_occ", 64'(occupancy), 64'(0));
    checkOutput("redir_addr", 64'(imemAddr), 64'h200);
    checkOutput("redir_req", 64'(imemReq), 64'(1));
    repeat (6) applyStimulus(0, 0, 0, 0, 1);

    // Faulting fetch at 0xC halts fetch until a redirect to 0x40.
    faultOn   = 1'b1;
    faultAddr = 32'hC;
    applyStimulus(0, 1, 32'h0, 0, 1);
    repeat (10) applyStimulus(0, 0, 0, 0, 1);
    #1;
    checkOutput("halt_req", 64'(imemReq), 64'(0));
    applyStimulus(0, 1, 32'h40, 0, 1);
    driveOnly(0, 0, 0, 0, 1);
    #1;
    checkOutput("resume_addr", 64'(imemAddr), 64'h40);
    checkOutput("resume_req", 64'(imemReq), 64'(1));
    repeat (6) applyStimulus(0, 0, 0, 0, 1);

    // Random traffic with occasional resets, redirects, waits and faults.
    randFaults = 1'b1;
    faultAddr  = 32'h0000_0104;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    end

    // PC wrap from RESET_PC = 0xFFFFFFF8 on the second instance.
    wReset = 1'b0;
    got    = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #1;
      if (wValid) begin
        gotPc[got]   = wPc;
        gotInst[got] = wInst;
        got++;
      end
      @(negedge clk);
    end
    checkOutput("wrap_count", 64'(got), 64'(4));
    for (int i = 0; i < got; i++) begin
      ePc = WRAP_PC + 32'(4 * i);
      checkOutput("wrap_pc", 64'(gotPc[i]), 64'(ePc));
      checkOutput("wrap_inst", 64'(gotInst[i]), 64'(memWord(ePc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
